// File: rtl/wavelet_ctrl_if.sv
// Sample-in and result-out handshake bundle for the wavelet filter-bank controller.
// The controller takes the slave modport; the environment driving samples takes master.
interface wavelet_ctrl_if #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_FILTERS   = 4,
    parameter int IDX_W         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
);
    logic signed [BITS_PER_ELEM-1:0] i_sample;
    logic                            i_sample_valid;
    logic                            o_sample_ready;
    logic [31:0]                     o_result;
    logic [IDX_W-1:0]                o_result_idx;
    logic                            o_result_valid;
    logic                            i_result_ready;

    modport slave (
        input  i_sample, i_sample_valid, i_result_ready,
        output o_sample_ready, o_result, o_result_idx, o_result_valid
    );

    modport master (
        output i_sample, i_sample_valid, i_result_ready,
        input  o_sample_ready, o_result, o_result_idx, o_result_valid
    );
endinterface

// File: rtl/wavelet_ctrl.sv
// Sequencer for the fir wavelet filter bank: keeps the shared tap window, strobes the
// filters once per primed sample, then serializes every filter's result with its index.
module wavelet_ctrl #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_ELEM      = 7,
    parameter int NUM_FILTERS   = 4,
    parameter int IDX_W         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    wavelet_ctrl_if.slave                     bus,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
    output logic                              o_start_calc,
    input  logic [NUM_FILTERS*32-1:0]         i_wavelets,
    output logic                              o_busy
);
    localparam int TAPS_W = NUM_ELEM * BITS_PER_ELEM;
    localparam int CNT_W  = $clog2(NUM_ELEM + 1);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(NUM_ELEM);
    localparam logic [CNT_W-1:0] CNT_PRIME  = CNT_W'(NUM_ELEM - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t            state;
    logic [TAPS_W-1:0] taps;
    logic [TAPS_W-1:0] taps_shifted;
    logic [CNT_W-1:0]  fill_cnt;
    logic [31:0]       capture_buf [NUM_FILTERS];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  next_idx;
    logic [31:0]       result;
    logic              result_valid;
    logic              start_calc;
    logic              accept;
    logic              primed_next;

    // Newest sample enters element 0; the oldest falls off the top of the window.
    if (NUM_ELEM > 1) begin : g_shift
        assign taps_shifted = {taps[TAPS_W-BITS_PER_ELEM-1:0], bus.i_sample};
    end else begin : g_single
        assign taps_shifted = bus.i_sample;
    end

    assign accept      = (state == IDLE) && bus.i_sample_valid;
    assign primed_next = (fill_cnt >= CNT_PRIME);
    assign next_idx    = idx + 1'b1;

    // NOTE: every state register below is updated with <= so all of them see the
    // pre-edge values of each other; a blocking = here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            taps         <= '0;
            fill_cnt     <= '0;
            idx          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            start_calc   <= 1'b0;
            // NOTE: the capture buffer is a small register file, not a RAM, so clearing
            // it in reset is cheap and keeps stale filter words from ever resurfacing.
            for (int k = 0; k < NUM_FILTERS; k++) begin
                capture_buf[k] <= '0;
            end
        end else begin
            start_calc <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        taps <= taps_shifted;
                        if (fill_cnt != CNT_FULL) begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                        if (primed_next) begin
                            state      <= CALC;
                            start_calc <= 1'b1;
                        end
                    end
                end

                CALC: begin
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    // Filter sums are only guaranteed this cycle; snapshot all of them.
                    for (int k = 0; k < NUM_FILTERS; k++) begin
                        capture_buf[k] <= i_wavelets[32*k +: 32];
                    end
                    idx          <= '0;
                    result       <= i_wavelets[31:0];
                    result_valid <= 1'b1;
                    state        <= OUT;
                end

                OUT: begin
                    if (bus.i_result_ready) begin
                        if (idx == LAST_IDX) begin
                            result_valid <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            idx    <= next_idx;
                            result <= capture_buf[next_idx];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_sample_ready = (state == IDLE);
    assign bus.o_result       = result;
    assign bus.o_result_idx   = idx;
    assign bus.o_result_valid = result_valid;
    assign o_taps             = taps;
    assign o_start_calc       = start_calc;
    assign o_busy             = (state != IDLE);
endmodule

// File: tb/tb_wavelet_ctrl.sv
// Directed bench for wavelet_ctrl: priming, readout timing, backpressure/isolation and
// reset mid-readout, with expected result words held in a scoreboard queue.
module tb_wavelet_ctrl;
    localparam int B     = 8;
    localparam int NE    = 7;
    localparam int NF    = 2;
    localparam int IDX_W = 1;

    typedef struct packed {
        logic [31:0]      word;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [NE*B-1:0]     taps;
    logic                start_calc;
    logic [NF*32-1:0]    wavelets;
    logic                busy;

    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t e;

    wavelet_ctrl_if #(.BITS_PER_ELEM(B), .NUM_FILTERS(NF)) bus ();

    wavelet_ctrl #(
        .BITS_PER_ELEM(B),
        .NUM_ELEM     (NE),
        .NUM_FILTERS  (NF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .o_taps      (taps),
        .o_start_calc(start_calc),
        .i_wavelets  (wavelets),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [B-1:0] s);
        bus.i_sample       = s;
        bus.i_sample_valid = 1'b1;
        tick();
        bus.i_sample_valid = 1'b0;
    endtask

    initial begin
        n_tests            = 0;
        n_fail             = 0;
        reset              = 1'b1;
        bus.i_sample       = '0;
        bus.i_sample_valid = 1'b0;
        bus.i_result_ready = 1'b0;
        wavelets           = '0;

        // Reset
        tick();
        tick();
        check("rst_ready", 64'(bus.o_sample_ready), 64'd1);
        check("rst_taps", 64'(taps), 64'd0);
        check("rst_valid", 64'(bus.o_result_valid), 64'd0);
        check("rst_start", 64'(start_calc), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(bus.o_result), 64'd0);
        reset = 1'b0;

        // Priming: six samples never strobe the filters
        for (int i = 1; i <= 6; i++) begin
            push(8'(i));
            check($sformatf("prime_start_%0d", i), 64'(start_calc), 64'd0);
            check($sformatf("prime_ready_%0d", i), 64'(bus.o_sample_ready), 64'd1);
        end

        wavelets           = {32'hFFFFFF80, 32'h00001234};
        bus.i_result_ready = 1'b1;
        sb.push_back('{word: 32'h00001234, idx: 1'b0});
        sb.push_back('{word: 32'hFFFFFF80, idx: 1'b1});

        push(8'd7);                         // now at t+1
        check("calc_start", 64'(start_calc), 64'd1);
        check("calc_taps", 64'(taps), 64'h01020304050607);
        check("calc_ready", 64'(bus.o_sample_ready), 64'd0);
        check("calc_busy", 64'(busy), 64'd1);
        tick();                             // t+2 capture
        check("cap_start", 64'(start_calc), 64'd0);
        check("cap_valid", 64'(bus.o_result_valid), 64'd0);
        tick();                             // t+3 first result
        e = sb.pop_front();
        check("rd0_valid", 64'(bus.o_result_valid), 64'd1);
        check("rd0_word", 64'(bus.o_result), 64'(e.word));
        check("rd0_idx", 64'(bus.o_result_idx), 64'(e.idx));
        tick();                             // t+4 second result
        e = sb.pop_front();
        check("rd1_valid", 64'(bus.o_result_valid), 64'd1);
        check("rd1_word", 64'(bus.o_result), 64'(e.word));
        check("rd1_idx", 64'(bus.o_result_idx), 64'(e.idx));
        tick();                             // t+5 back to idle
        check("rd_done_valid", 64'(bus.o_result_valid), 64'd0);
        check("rd_done_ready", 64'(bus.o_sample_ready), 64'd1);
        check("rd_done_busy", 64'(busy), 64'd0);

        // Next sample slides the window and restarts immediately
        bus.i_result_ready = 1'b0;
        sb.push_back('{word: 32'h00001234, idx: 1'b0});
        sb.push_back('{word: 32'hFFFFFF80, idx: 1'b1});
        push(8'd8);
        check("s8_taps", 64'(taps), 64'h02030405060708);
        check("s8_start", 64'(start_calc), 64'd1);
        tick();                             // capture
        tick();                             // OUT, idx 0, ready held low

        // Backpressure and isolation
        bus.i_sample       = 8'h55;
        bus.i_sample_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wavelets = {32'($urandom()), 32'($urandom())};
            check($sformatf("bp_valid_%0d", c), 64'(bus.o_result_valid), 64'd1);
            check($sformatf("bp_word_%0d", c), 64'(bus.o_result), 64'(sb[0].word));
            check($sformatf("bp_idx_%0d", c), 64'(bus.o_result_idx), 64'(sb[0].idx));
            check($sformatf("bp_taps_%0d", c), 64'(taps), 64'h02030405060708);
            check($sformatf("bp_ready_%0d", c), 64'(bus.o_sample_ready), 64'd0);
            tick();
        end
        bus.i_sample_valid = 1'b0;

        // Reset mid-OUT abandons the sequence
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("mrst_valid", 64'(bus.o_result_valid), 64'd0);
        check("mrst_ready", 64'(bus.o_sample_ready), 64'd1);
        check("mrst_taps", 64'(taps), 64'd0);
        check("mrst_idx", 64'(bus.o_result_idx), 64'd0);

        for (int i = 1; i <= 6; i++) begin
            push(8'(8'h10 + i));
            check($sformatf("reprime_start_%0d", i), 64'(start_calc), 64'd0);
        end
        wavelets           = {32'h00000001, 32'hDEADBEEF};
        bus.i_result_ready = 1'b1;
        sb.push_back('{word: 32'hDEADBEEF, idx: 1'b0});
        sb.push_back('{word: 32'h00000001, idx: 1'b1});
        push(8'h17);
        check("reprime_start_7", 64'(start_calc), 64'd1);
        check("reprime_taps", 64'(taps), 64'h11121314151617);
        tick();                             // capture
        tick();                             // first result
        wavelets = {32'hCAFEF00D, 32'h0BADC0DE};

        // Drain the remaining results against the scoreboard, bounded
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            if (bus.o_result_valid && bus.i_result_ready) begin
                e = sb.pop_front();
                check("drain_word", 64'(bus.o_result), 64'(e.word));
                check("drain_idx", 64'(bus.o_result_idx), 64'(e.idx));
            end
            tick();
        end
        check("drain_left", 64'(sb.size()), 64'd0);
        check("drain_valid", 64'(bus.o_result_valid), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wavelet_ctrl.md
Name: wavelet_ctrl

Overview:
- Sequencer and result serializer for the fir wavelet filter bank.
- Accepts a serial sample stream through a valid/ready handshake and maintains the NUM_ELEM-deep sample window that drives the taps bus shared by all NUM_FILTERS fir instances.
- Pulses the filter start-calculation strobe once per new sample after the window is primed.
- Captures every filter's 32-bit output and streams the results out one per handshake, each tagged with its filter index.

Parameters:
- BITS_PER_ELEM, 8, width of one sample / tap element.
- NUM_ELEM, 7, window depth; must equal the fir NUM_ELEM.
- NUM_FILTERS, 4, number of fir instances (center frequencies) served; must be ≥1.
- IDX_W, (NUM_FILTERS>1 ? $clog2(NUM_FILTERS) : 1), width of the result index.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- i_sample  in  BITS_PER_ELEM  signed input sample.
- i_sample_valid  in  1  i_sample valid.
- o_sample_ready  out  1  controller can accept a sample.
- o_taps  out  NUM_ELEM*BITS_PER_ELEM  sample window to all fir instances; element 0 at bits [BITS_PER_ELEM-1:0].
- o_start_calc  out  1  one-cycle strobe to all fir instances.
- i_wavelets  in  NUM_FILTERS*32  concatenated fir outputs; filter k at bits [32k+31:32k].
- o_result  out  32  signed result word.
- o_result_idx  out  IDX_W  filter index of o_result.
- o_result_valid  out  1  o_result and o_result_idx valid.
- i_result_ready  in  1  downstream accepts the result.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, wins over all other inputs, any state):
  - state goes to IDLE; window, fill counter, capture buffer and index are cleared.
  - Outputs next cycle: o_taps=0, o_start_calc=0, o_result=0, o_result_idx=0, o_result_valid=0, o_busy=0, o_sample_ready=1.
- Sample acceptance:
  - A sample is accepted on a cycle where i_sample_valid && o_sample_ready.
  - o_sample_ready=1 only in IDLE and is decoded combinationally from state.
  - i_sample_valid outside IDLE is ignored and o_taps does not change.
- Window shift on acceptance: o_taps <= {o_taps[(NUM_ELEM-1)*B-1:0], i_sample}. The newest sample enters element 0; the oldest sample drops off the top.
- Fill counter: increments on each acceptance and saturates at NUM_ELEM. The window is primed once the count reaches NUM_ELEM.
- FSM states: IDLE, CALC, CAPTURE, OUT.
  - IDLE: on acceptance, go to CALC if the window will be primed after this sample (count+1 ≥ NUM_ELEM); otherwise stay in IDLE.
  - CALC: o_start_calc=1 for exactly this cycle, with o_taps stable; unconditionally go to CAPTURE.
  - CAPTURE: fir sums are valid this cycle. Register all of i_wavelets into the capture buffer, set idx=0, go to OUT.
  - OUT: o_result_valid=1, o_result=buffer[idx], o_result_idx=idx.
    - On i_result_ready with idx<NUM_FILTERS-1: idx increments.
    - On i_result_ready with idx==NUM_FILTERS-1: o_result_valid drops next cycle and the FSM returns to IDLE.
- Latency:
  - Sample accepted in cycle t (primed case): start_calc at t+1, capture at t+2, first result valid at t+3.
  - With i_result_ready held high, the last result is at t+2+NUM_FILTERS and o_sample_ready returns at t+3+NUM_FILTERS.
- Backpressure: while in OUT with i_result_ready=0, o_result, o_result_idx and o_result_valid hold stable indefinitely.
- Isolation: changes on i_wavelets after CAPTURE have no effect on the results being streamed.
- Arithmetic: no arithmetic on the results; the 32-bit words are passed through unchanged. o_result is registered, with no combinational path from i_wavelets to o_result.
- NUM_FILTERS=1: OUT lasts exactly one handshake and o_result_idx is constantly 0.
- Reset mid-operation: an in-flight result sequence is abandoned with no further valid. After reset, NUM_ELEM new samples are required before the next o_start_calc.

Test Plan:
- Reset: assert reset 2 cycles, then release → o_sample_ready=1, o_taps=0, o_result_valid=0, o_start_calc=0, o_busy=0.
- Priming (NUM_ELEM=7, NUM_FILTERS=2): push samples 1..6 → no o_start_calc and o_sample_ready stays 1. Push sample 7 at cycle t → o_start_calc=1 only at t+1, with o_taps=0x01020304050607.
- Readout: fir stub drives filter0=32'h00001234 and filter1=32'hFFFFFF80, with i_result_ready=1 → at t+3 result 0x00001234 idx 0; at t+4 result 0xFFFFFF80 idx 1; at t+5 o_result_valid=0 and o_sample_ready=1. Next sample 8 → o_taps=0x02030405060708 and start_calc the following cycle.
- Backpressure and isolation: hold i_result_ready=0 for 5 cycles at idx 0, with i_sample_valid=1 and the stub changing i_wavelets → o_result stays 0x00001234, o_taps is unchanged, o_sample_ready=0.
- Reset mid-OUT: assert reset while o_result_valid=1, idx=0 → next cycle o_result_valid=0 and o_sample_ready=1. Six new samples give no start_calc; the seventh gives start_calc.
